// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl clock-enable generator.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPend
  } state_e;

  localparam int unsigned CLK_DIV_CTRL_W_DEF = 8;
  localparam int unsigned CLK_DIV_CTRL_CNT_W = 16;

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// Period counter: counts 0..N-1 while enabled, decodes wrap, tick and the divided waveform.
module clk_div_ctrl_cnt
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned W = CLK_DIV_CTRL_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_div,
  output logic         o_wrap,
  output logic         o_tick,
  output logic         o_clk_div
);

  localparam int unsigned WH = W + 1;

  logic [W-1:0] r_cnt;
  logic [W:0]   w_half;
  logic         w_wrap;

  assign w_wrap = (r_cnt == (i_div - W'(1)));
  // ceil(N/2), computed one bit wider so N = 2^W-1 does not overflow
  assign w_half = ({1'b0, i_div} + WH'(1)) >> 1;

  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_wrap    = i_en && w_wrap;
  assign o_tick    = i_en && w_wrap;
  assign o_clk_div = i_en && ({1'b0, r_cnt} < w_half);

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-enable generator with boundary-aligned ratio changes and start/stop.
// Optional tick counter enabled by defining CLK_DIV_CTRL_CNT_EN.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned W           = CLK_DIV_CTRL_W_DEF,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_run,
  input  logic                          i_cfg_valid,
  input  logic [W-1:0]                  i_cfg_div,
  output logic                          o_cfg_ready,
  output logic                          o_tick,
  output logic                          o_clk_div,
  output logic                          o_busy,
  output logic [W-1:0]                  o_active_div
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [CLK_DIV_CTRL_CNT_W-1:0] o_tick_count
`endif
);

  state_e       r_state;
  logic [W-1:0] r_active_div;
  logic [W-1:0] r_pend_div;
  logic [W-1:0] w_cfg_div;
  logic         w_accept;
  logic         w_wrap;
  logic         w_busy;

  assign w_cfg_div = (i_cfg_div == '0) ? W'(1) : i_cfg_div;
  assign w_accept  = i_cfg_valid && o_cfg_ready;
  assign w_busy    = (r_state != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_active_div <= W'(DEFAULT_DIV);
      r_pend_div   <= W'(DEFAULT_DIV);
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) r_active_div <= w_cfg_div;
          if (i_run) r_state <= StRun;
        end
        StRun: begin
          if (w_wrap) begin
            // Accept on the wrap cycle takes effect for the very next period
            if (w_accept) r_active_div <= w_cfg_div;
            if (!i_run) r_state <= StIdle;
          end else if (w_accept) begin
            r_pend_div <= w_cfg_div;
            r_state    <= StPend;
          end
        end
        StPend: begin
          if (w_wrap) begin
            r_active_div <= r_pend_div;
            r_state      <= i_run ? StRun : StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  clk_div_ctrl_cnt #(
    .W(W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_busy),
    .i_div    (r_active_div),
    .o_wrap   (w_wrap),
    .o_tick   (o_tick),
    .o_clk_div(o_clk_div)
  );

  assign o_cfg_ready  = (r_state != StPend);
  assign o_busy       = w_busy;
  assign o_active_div = r_active_div;

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [CLK_DIV_CTRL_CNT_W-1:0] r_tick_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_count <= '0;
    end else if (o_tick) begin
      r_tick_count <= r_tick_count + CLK_DIV_CTRL_CNT_W'(1);
    end
  end

  assign o_tick_count = r_tick_count;
`endif

endmodule
